// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and default parameters for the MEM-stage data memory and its write buffer.
package dmem_pkg;
    localparam int AW_D        = 10;
    localparam int DW_D        = 32;
    localparam int WB_DEPTH_D  = 4;
    localparam int WR_CYCLES_D = 2;
    typedef struct packed {
        logic [AW_D-1:0] addr;
        logic [DW_D-1:0] data;
    } wb_entry_t;
    typedef enum logic {IDLE, WRITE} drain_state_t;
endpackage

// File: rtl/dmem_wbuf_fifo.sv
// wbuf_fifo: in-order circular store buffer exposing every slot and its valid bit for forwarding.
module wbuf_fifo
    import dmem_pkg::*;
#(
    parameter int  DEPTH = WB_DEPTH_D,
    parameter type T     = wb_entry_t
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  T                         i_data,
    output T                         o_entries [DEPTH],
    output logic [DEPTH-1:0]         o_valid,
    output logic [$clog2(DEPTH)-1:0] o_head,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PW = $clog2(DEPTH);
    T                r_q [DEPTH];
    logic [PW-1:0]   r_head, r_tail;
    logic [PW:0]     r_count;
    logic [PW-1:0]   w_off [DEPTH];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= r_tail + 1'b1;
            if (i_pop) r_head <= r_head + 1'b1;
            r_count <= r_count + (PW+1)'(i_push) - (PW+1)'(i_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (i_push) r_q[r_tail] <= i_data;
    end
    // A slot is live when its distance from head is below the occupancy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_off[i]   = PW'(i) - r_head;
            o_valid[i] = {1'b0, w_off[i]} < r_count;
        end
    end
    assign o_entries = r_q;
    assign o_head    = r_head;
    assign o_count   = r_count;
endmodule

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: data memory with a posted in-order write buffer, background drain FSM and store-to-load forwarding.
module dmem_wbuf
    import dmem_pkg::*;
#(
    parameter int AW        = AW_D,
    parameter int DW        = DW_D,
    parameter int WB_DEPTH  = WB_DEPTH_D,
    parameter int WR_CYCLES = WR_CYCLES_D
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [31:0]                 addr_MEM,
    input  logic [DW-1:0]               wdata_MEM,
    input  logic                        memwrite_MEM,
    output logic [DW-1:0]               rdata_MEM,
    output logic [$clog2(WB_DEPTH):0]   wb_count,
    output logic                        wb_empty,
    output logic                        wb_full,
    output logic                        drain_busy,
    output logic                        ovf_err
);
    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;
    logic [DW-1:0]  r_mem [2**AW];
    drain_state_t   r_state, w_state_nx;
    logic [CW-1:0]  r_cnt, w_cnt_nx;
    logic           r_ovf;
    logic [AW-1:0]  w_addr;
    logic           w_retire, w_push, w_hit, w_unused_hi;
    logic [DW-1:0]  w_fwd;
    entry_t         w_new, w_head_e;
    entry_t         w_entries [WB_DEPTH];
    logic [WB_DEPTH-1:0] w_valid;
    logic [PW-1:0]  w_head, w_slot;
    assign w_addr      = addr_MEM[AW-1:0];
    assign w_unused_hi = &{1'b0, addr_MEM[31:AW]};
    assign w_retire    = (r_state == WRITE) && (r_cnt == '0);
    // A full buffer still accepts a store when the head retires on the same edge.
    assign w_push      = memwrite_MEM && (!wb_full || w_retire);
    assign w_new       = '{addr: w_addr, data: wdata_MEM};
    wbuf_fifo #(.DEPTH(WB_DEPTH), .T(entry_t)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_pop     (w_retire),
        .i_data    (w_new),
        .o_entries (w_entries),
        .o_valid   (w_valid),
        .o_head    (w_head),
        .o_count   (wb_count)
    );
    assign w_head_e   = w_entries[w_head];
    assign wb_empty   = wb_count == '0;
    assign wb_full    = wb_count == (PW+1)'(WB_DEPTH);
    assign drain_busy = r_state == WRITE;
    assign ovf_err    = r_ovf;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if (memwrite_MEM && !w_push) r_ovf <= 1'b1;
        end
    end
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        if (r_state == IDLE && !wb_empty) begin
            w_state_nx = WRITE;
            w_cnt_nx   = CW'(WR_CYCLES - 1);
        end else if (r_state == WRITE && r_cnt != '0) begin
            w_cnt_nx = r_cnt - 1'b1;
        end else if (w_retire) begin
            w_state_nx = (wb_count > (PW+1)'(1) || w_push) ? WRITE : IDLE;
            w_cnt_nx   = CW'(WR_CYCLES - 1);
        end
    end
    always_ff @(posedge clk) begin
        if (w_retire) r_mem[w_head_e.addr] <= w_head_e.data;
    end
    // Walk oldest to youngest so the youngest matching store wins.
    always_comb begin
        w_hit  = 1'b0;
        w_fwd  = '0;
        w_slot = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            w_slot = w_head + PW'(k);
            if (w_valid[w_slot] && w_entries[w_slot].addr == w_addr) begin
                w_hit = 1'b1;
                w_fwd = w_entries[w_slot].data;
            end
        end
    end
    assign rdata_MEM = w_hit ? w_fwd : r_mem[w_addr];
endmodule

// File: tb/tb_dmem_wbuf.sv
// tb_dmem_wbuf: directed scoreboard bench driving a WR_CYCLES=2 and a WR_CYCLES=4 instance in lockstep.
module tb_dmem_wbuf;
    logic clk = 1'b0, rst = 1'b1, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rd2, rd4;
    logic [2:0]  cnt2, cnt4;
    logic e2, e4, f2, f4, b2, b4, o2, o4;
    int vectors = 0, miscompares = 0;
    logic [31:0] ref2 [int];
    logic [31:0] ref4 [int];
    logic [31:0] exp_q [$];
    always #5 clk = ~clk;
    dmem_wbuf dut2 (
        .clk(clk), .rst(rst), .addr_MEM(addr), .wdata_MEM(wdata), .memwrite_MEM(we),
        .rdata_MEM(rd2), .wb_count(cnt2), .wb_empty(e2), .wb_full(f2),
        .drain_busy(b2), .ovf_err(o2)
    );
    dmem_wbuf #(.WR_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .addr_MEM(addr), .wdata_MEM(wdata), .memwrite_MEM(we),
        .rdata_MEM(rd4), .wb_count(cnt4), .wb_empty(e4), .wb_full(f4),
        .drain_busy(b4), .ovf_err(o4)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic ld(input int a);
        int idx;
        idx = a & 'h3ff;
        addr = a;
        we = 1'b0;
        exp_q.push_back(ref2[idx]);
        exp_q.push_back(ref4[idx]);
        #1;
        chk("load_w2", rd2, exp_q.pop_front());
        chk("load_w4", rd4, exp_q.pop_front());
        tick;
    endtask
    task automatic st(input int a, input logic [31:0] d, input bit acc4 = 1'b1);
        int idx;
        idx = a & 'h3ff;
        addr = a;
        wdata = d;
        we = 1'b1;
        #1;
        if (ref2.exists(idx)) begin
            exp_q.push_back(ref2[idx]);
            exp_q.push_back(ref4[idx]);
            chk("prestore_w2", rd2, exp_q.pop_front());
            chk("prestore_w4", rd4, exp_q.pop_front());
        end
        tick;
        we = 1'b0;
        ref2[idx] = d;
        if (acc4) ref4[idx] = d;
    endtask
    task automatic drain;
        int n;
        n = 0;
        we = 1'b0;
        while (!(e2 && e4) && n < 200) begin
            tick;
            n++;
        end
        chk("drain_done", {28'd0, e2, e4, b2, b4}, 32'hC);
    endtask
    initial begin
        int c2 [6] = '{1, 2, 3, 3, 4, 4};
        int c4 [6] = '{1, 2, 3, 4, 4, 4};
        int v4 [6] = '{0, 0, 0, 0, 1, 1};
        tick;
        chk("rst_cnt2", cnt2, 0);
        chk("rst_flags2", {28'd0, e2, f2, b2, o2}, 32'h8);
        chk("rst_flags4", {28'd0, e4, f4, b4, o4}, 32'h8);
        rst = 1'b0;
        tick;
        st(5, 32'h0);
        st(3, 32'h33);
        st(24, 32'h24);
        drain;
        // forwarding and array write latency
        st(5, 32'hDEADBEEF);
        chk("mem5_E", dut2.r_mem[5], 32'h0);
        ld(5);
        chk("mem5_E1", dut2.r_mem[5], 32'h0);
        tick;
        chk("mem5_E2", dut2.r_mem[5], 32'h0);
        tick;
        chk("mem5_E3", dut2.r_mem[5], 32'hDEADBEEF);
        drain;
        ld(5);
        // youngest of two same-address stores wins
        st(7, 32'hA);
        ld(7);
        st(7, 32'hB);
        ld(7);
        drain;
        ld(7);
        // upper address bits alias
        st('h405, 32'h55);
        ld('h005);
        drain;
        ld('h005);
        ld('h805);
        // five-plus stores: slow drain drops the 5th, fast drain keeps all; 6th rides a retire while full
        for (int i = 0; i < 6; i++) begin
            st(20 + i, 32'h1000 + i, i != 4);
            chk("cnt_w2", cnt2, c2[i]);
            chk("cnt_w4", cnt4, c4[i]);
            chk("ovf_w2", o2, 0);
            chk("ovf_w4", o4, v4[i]);
        end
        chk("full_w2", f2, 1);
        ld(24);
        drain;
        ld(24);
        ld(25);
        chk("ovf_sticky_w4", o4, 1);
        chk("ovf_clean_w2", o2, 0);
        // reset while the drain is mid-write
        st(3, 32'h11);
        tick;
        rst = 1'b1;
        #1;
        chk("rst_mid_empty", {30'd0, e2, e4}, 32'h3);
        chk("rst_mid_busy", {30'd0, b2, b4}, 32'h0);
        chk("rst_mid_ovf4", o4, 0);
        tick;
        tick;
        tick;
        rst = 1'b0;
        ref2[3] = 32'h33;
        ref4[3] = 32'h33;
        tick;
        ld(3);
        chk("mem3_after_rst", dut2.r_mem[3], 32'h33);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
